// File: rtl/cascaded_interpolator_pkg.sv
// cascaded_interpolator_pkg: shared FSM state type and port-width helpers.
//   state_t - IDLE (waiting for a sample) / EMIT (producing R high-rate samples)
//   cnt_w   - width of the R field and the emit counter
//   ord_w   - width of the order field K
package cascaded_interpolator_pkg;

    typedef enum logic {IDLE, EMIT} state_t;

    function automatic int cnt_w(input int max_interp);
        return (max_interp > 1) ? $clog2(max_interp) : 1;
    endfunction

    function automatic int ord_w(input int max_stages);
        return (max_stages > 0) ? $clog2(max_stages + 1) : 1;
    endfunction

endpackage

// File: rtl/cic_stage.sv
// cic_stage: one comb section plus one integrator section of a CIC chain.
//   clock, reset   - clock, asynchronous active-high reset
//   clr_i          - drop comb history / integrator state (order change)
//   comb_en_i      - comb advances one input-rate sample
//   integ_en_i     - integrator advances one output-rate sample
//   comb_i/comb_o  - comb input and x[n]-x[n-1] (combinational)
//   integ_i/integ_o- integrator input and running sum (combinational)
//   ovf_o          - signed overflow of this cycle's integrator add
//                    (only with CASCADED_INTERPOLATOR_OVERFLOW_EN)
module cic_stage #(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         comb_en_i,
    input  logic         integ_en_i,
    input  logic [W-1:0] comb_i,
    input  logic [W-1:0] integ_i,
    output logic [W-1:0] comb_o,
    output logic [W-1:0] integ_o
`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
    ,
    output logic         ovf_o
`endif
);

    logic [W-1:0] dly_q;
    logic [W-1:0] integ_q;

    // A clear coincides with acceptance, so the new sample must see zero history.
    assign comb_o  = comb_i - (clr_i ? '0 : dly_q);
    assign integ_o = integ_q + integ_i;

`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
    assign ovf_o = integ_en_i && (integ_q[W-1] == integ_i[W-1]) && (integ_o[W-1] != integ_q[W-1]);
`endif

    // The integrator may still be finishing the previous sample while clr_i is
    // high; its sum still reaches the output, only the stored state is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dly_q   <= '0;
            integ_q <= '0;
        end else begin
            if (comb_en_i)
                dly_q <= comb_i;
            if (clr_i)
                integ_q <= '0;
            else if (integ_en_i)
                integ_q <= integ_o;
        end
    end

endmodule

// File: rtl/cascaded_interpolator.sv
// cascaded_interpolator: CIC interpolator, up to MAX_CASCADED_STAGES comb/integrator pairs.
//   clock, reset         - clock, asynchronous active-high reset
//   ready                - a sample can be accepted this cycle
//   data_in/_valid       - low-rate sample, accepted when valid and ready
//   length_interpolation - ratio R (0 means 1), latched on acceptance
//   order_rolloff        - order K (clamped), latched on acceptance
//   data_out/_valid      - registered high-rate samples, R per accepted sample
//   overflow             - sticky integrator overflow flag, present only when
//                          CASCADED_INTERPOLATOR_OVERFLOW_EN is defined
module cascaded_interpolator
    import cascaded_interpolator_pkg::*;
#(
    parameter int MAX_INTERPOLATION   = 1024,
    parameter int INPUT_DATA_BITS     = 32,
    parameter int OUTPUT_DATA_BITS    = 64,
    parameter int MAX_CASCADED_STAGES = 3,
    parameter int SIGNED              = 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    output logic                                  ready,
    input  logic [INPUT_DATA_BITS-1:0]            data_in,
    input  logic                                  data_in_valid,
    input  logic [cnt_w(MAX_INTERPOLATION)-1:0]   length_interpolation,
    input  logic [ord_w(MAX_CASCADED_STAGES)-1:0] order_rolloff,
    output logic [OUTPUT_DATA_BITS-1:0]           data_out,
    output logic                                  data_out_valid
`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
    ,
    output logic                                  overflow
`endif
);

    localparam int CW = cnt_w(MAX_INTERPOLATION);
    localparam int KW = ord_w(MAX_CASCADED_STAGES);
    localparam int OB = OUTPUT_DATA_BITS;
    localparam int IB = INPUT_DATA_BITS;
    localparam int NS = MAX_CASCADED_STAGES;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, r_q, r_d;
    logic [KW-1:0] k_q, k_d;
    logic [OB-1:0] samp_q, samp_d, dout_q, dout_d;
    logic          valid_q;
    logic          emit, last, accept, clr;
    logic [OB-1:0] comb_c [NS+1];
    logic [OB-1:0] integ_c [NS+1];

    assign comb_c[0]  = {{(OB-IB){SIGNED != 0 && data_in[IB-1]}}, data_in};
    // Zero-stuffing: the comb result enters the integrators only on the first emit cycle.
    assign integ_c[0] = (cnt_q == '0) ? samp_q : '0;

    always_comb begin
        emit    = state_q == EMIT;
        last    = emit && (cnt_q == r_q - CW'(1));
        ready   = !emit || last;
        accept  = data_in_valid && ready;
        k_d     = accept ? ((order_rolloff > KW'(NS)) ? KW'(NS) : order_rolloff) : k_q;
        r_d     = accept ? ((length_interpolation == '0) ? CW'(1) : length_interpolation) : r_q;
        clr     = accept && (k_d != k_q);
        state_d = accept ? EMIT : (last ? IDLE : state_q);
        cnt_d   = (accept || last) ? '0 : (emit ? cnt_q + CW'(1) : cnt_q);
        samp_d  = accept ? comb_c[k_d] : samp_q;
        dout_d  = emit ? integ_c[k_q] : dout_q;
    end

`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
    logic [NS-1:0] ovf;
    logic          ovf_q;
`endif

    for (genvar s = 0; s < NS; s++) begin : g_stage
        cic_stage #(.W(OB)) u_stage (
            .clock      (clock),
            .reset      (reset),
            .clr_i      (clr),
            .comb_en_i  (accept),
            .integ_en_i (emit && (KW'(s) < k_q)),
            .comb_i     (comb_c[s]),
            .integ_i    (integ_c[s]),
            .comb_o     (comb_c[s+1]),
            .integ_o    (integ_c[s+1])
`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
            ,
            .ovf_o      (ovf[s])
`endif
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            k_q     <= '0;
            samp_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            k_q     <= k_d;
            samp_q  <= samp_d;
            dout_q  <= dout_d;
            valid_q <= emit;
        end
    end

`ifdef CASCADED_INTERPOLATOR_OVERFLOW_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_q | (|ovf);
    end

    assign overflow = ovf_q;
`endif

    assign data_out       = dout_q;
    assign data_out_valid = valid_q;

endmodule
